// File: rtl/compressed_byte_packer_if.sv
// Byte-in / word-out bus of compressed_byte_packer.
// master: the packer itself (consumes bytes, produces words).
// slave:  the environment (drives bytes, accepts words).
interface compressed_byte_packer_if #(
  parameter int ADDR_W = 4
);
  logic              byte_valid;
  logic [7:0]        byte_in;
  logic              frame_end;
  logic              word_valid;
  logic              word_ready;
  logic [31:0]       word_data;
  logic [3:0]        word_keep;
  logic              word_last;
  logic [ADDR_W:0]   fifo_level;
  logic              overflow;

  modport master (
    input  byte_valid, byte_in, frame_end, word_ready,
    output word_valid, word_data, word_keep, word_last, fifo_level, overflow
  );

  modport slave (
    output byte_valid, byte_in, frame_end, word_ready,
    input  word_valid, word_data, word_keep, word_last, fifo_level, overflow
  );
endinterface

// File: rtl/compressed_byte_packer.sv
// compressed_byte_packer: packs an 8-bit compressed stream into 32-bit words,
// tags the final word of each frame through a one-word stage, and buffers the
// words in a first-word-fall-through FIFO. Upstream cannot be stalled, so a
// write into a full FIFO is dropped and latches the sticky overflow flag.
// Optional feature: define PACKER_FRAME_CNT_EN to add the frame_count output.
module compressed_byte_packer #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  compressed_byte_packer_if.master bus
`ifdef PACKER_FRAME_CNT_EN
  ,
  output logic [15:0]              frame_count
`endif
);

  logic [23:0]       acc;
  logic [1:0]        cnt;
  logic [31:0]       stage_data;
  logic              stage_valid;
  logic              pending;

  logic              exec;
  logic              wr_en;
  logic              wr_last;
  logic [31:0]       pk_data;
  logic [3:0]        pk_keep;
  logic [31:0]       wr_data;
  logic [3:0]        wr_keep;

  logic [36:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level;
  logic              ovf;
  logic              full;
  logic              pop;
  logic              accept;

  // A frame end executes on a byte-free cycle, either directly or deferred via pending.
  assign exec = !bus.byte_valid && (bus.frame_end || pending);

  // Select the single FIFO write of this cycle (little-endian lane order).
  always_comb begin
    wr_en   = 1'b0;
    wr_last = 1'b0;
    pk_data = '0;
    pk_keep = '0;
    if (bus.byte_valid && stage_valid) begin
      wr_en   = 1'b1;
      pk_data = stage_data;
      pk_keep = '1;
    end else if (exec && stage_valid) begin
      wr_en   = 1'b1;
      wr_last = 1'b1;
      pk_data = stage_data;
      pk_keep = '1;
    end else if (exec && cnt != 2'd0) begin
      wr_en   = 1'b1;
      wr_last = 1'b1;
      // acc is never cleared, so lanes at or above cnt may hold stale bytes: mask them.
      for (int unsigned i = 0; i < 3; i++) begin
        if (i < 32'(cnt)) begin
          pk_keep[i]          = 1'b1;
          pk_data[8*i +: 8]   = acc[8*i +: 8];
        end
      end
    end
  end

  assign wr_data = BIG_ENDIAN ? {pk_data[7:0], pk_data[15:8], pk_data[23:16], pk_data[31:24]}
                              : pk_data;
  assign wr_keep = BIG_ENDIAN ? {pk_keep[0], pk_keep[1], pk_keep[2], pk_keep[3]} : pk_keep;

  // Byte accumulator, completed-word stage and deferred frame-end flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      cnt         <= '0;
      stage_data  <= '0;
      stage_valid <= 1'b0;
      pending     <= 1'b0;
    end else if (bus.byte_valid) begin
      if (stage_valid) begin
        acc[7:0]    <= bus.byte_in;
        cnt         <= 2'd1;
        stage_valid <= 1'b0;
      end else if (cnt == 2'd3) begin
        stage_data  <= {bus.byte_in, acc};
        stage_valid <= 1'b1;
        cnt         <= '0;
      end else begin
        acc[8*cnt +: 8] <= bus.byte_in;
        cnt             <= cnt + 2'd1;
      end
      if (bus.frame_end) pending <= 1'b1;
    end else if (exec) begin
      stage_valid <= 1'b0;
      cnt         <= '0;
      pending     <= 1'b0;
    end
  end

`ifdef PACKER_FRAME_CNT_EN
  // Count every executed frame end, including those with nothing to push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_count <= '0;
    else if (exec) frame_count <= frame_count + 16'd1;
  end
`endif

  assign full   = (level == (ADDR_W+1)'(DEPTH));
  assign pop    = (level != '0) && bus.word_ready;
  assign accept = wr_en && (!full || pop);

  // FIFO storage, pointers, registered level and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= {wr_data, wr_keep, wr_last};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (wr_en && !accept) ovf <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({accept, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign bus.word_valid = (level != '0);
  assign {bus.word_data, bus.word_keep, bus.word_last} = mem[rd_ptr];
  assign bus.fifo_level = level;
  assign bus.overflow   = ovf;

endmodule
